// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite response encodings and a small helper for the write slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Decoded register hit answers OKAY; anything past the register file is a slave error.
  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Register storage for the AXI-lite write slave, packed onto a flat bus.
// Byte-lane strobes are honoured when AXI_LITE_WSTRB_EN is defined.
module axi_lite_regfile #(
  parameter int DATA_WD  = 8,
  parameter int NUM_REGS = 16,
  parameter int IDX_WD   = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          we,
  input  logic [IDX_WD-1:0]             idx,
  input  logic [DATA_WD-1:0]            wdata,
`ifdef AXI_LITE_WSTRB_EN
  input  logic [DATA_WD/8-1:0]          wstrb,
`endif
  output logic [NUM_REGS*DATA_WD-1:0]   reg_flat
);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [DATA_WD-1:0] r_val;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_val <= '0;
      end else if (we && (idx == IDX_WD'(g))) begin
`ifdef AXI_LITE_WSTRB_EN
        for (int k = 0; k < DATA_WD/8; k++) begin
          if (wstrb[k]) r_val[k*8 +: 8] <= wdata[k*8 +: 8];
        end
`else
        r_val <= wdata;
`endif
      end
    end

    assign reg_flat[g*DATA_WD +: DATA_WD] = r_val;
  end

endmodule

// File: rtl/axi_lite_write_slave.sv
// AXI-lite write responder: one-beat AW/W buffers, register commit, B response.
// Optional byte strobes via AXI_LITE_WSTRB_EN.
module axi_lite_write_slave
  import axi_lite_pkg::*;
#(
  parameter  int DATA_WD  = 8,
  parameter  int ADDR_WD  = 8,
  parameter  int NUM_REGS = 16,
  localparam int ADDR_LSB = $clog2(DATA_WD/8),
  localparam int IDX_WD   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [ADDR_WD-1:0]            awaddr,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DATA_WD-1:0]            wdata,
`ifdef AXI_LITE_WSTRB_EN
  input  logic [DATA_WD/8-1:0]          wstrb,
`endif
  input  logic                          wvalid,
  output logic                          wready,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  output logic [NUM_REGS*DATA_WD-1:0]   reg_flat,
  output logic                          wr_pulse,
  output logic [IDX_WD-1:0]             wr_idx
);

  localparam int AIDX_WD = ADDR_WD - ADDR_LSB;
  localparam int CMP_WD  = AIDX_WD + 1;

  logic                 r_init_done;
  logic                 r_aw_full;
  logic                 r_w_full;
  logic [AIDX_WD-1:0]   r_aidx;
  logic [DATA_WD-1:0]   r_wdata;
`ifdef AXI_LITE_WSTRB_EN
  logic [DATA_WD/8-1:0] r_wstrb;
`endif
  logic                 r_bvalid;
  logic [1:0]           r_bresp;
  logic                 r_wr_pulse;
  logic [IDX_WD-1:0]    r_wr_idx;

  logic                 w_aw_fire;
  logic                 w_w_fire;
  logic                 w_commit;
  logic                 w_in_range;
  logic [IDX_WD-1:0]    w_idx;

  assign awready    = r_init_done && !r_aw_full;
  assign wready     = r_init_done && !r_w_full;
  assign w_aw_fire  = awvalid && awready;
  assign w_w_fire   = wvalid && wready;

  // A buffered pair commits only when the B slot is free or draining this cycle.
  assign w_commit   = r_aw_full && r_w_full && (!r_bvalid || bready);
  assign w_in_range = {1'b0, r_aidx} < CMP_WD'(NUM_REGS);
  assign w_idx      = IDX_WD'(r_aidx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_aw_full <= 1'b0;
      r_aidx    <= '0;
    end else if (w_aw_fire) begin
      r_aw_full <= 1'b1;
      r_aidx    <= awaddr[ADDR_WD-1:ADDR_LSB];
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_w_full <= 1'b0;
      r_wdata  <= '0;
`ifdef AXI_LITE_WSTRB_EN
      r_wstrb  <= '0;
`endif
    end else if (w_w_fire) begin
      r_w_full <= 1'b1;
      r_wdata  <= wdata;
`ifdef AXI_LITE_WSTRB_EN
      r_wstrb  <= wstrb;
`endif
    end else if (w_commit) begin
      r_w_full <= 1'b0;
    end
  end

  // bresp only moves on a commit, so it holds while a response is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= 1'b0;
      r_wr_idx   <= '0;
    end else begin
      r_wr_pulse <= w_commit && w_in_range;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= resp_for(w_in_range);
        if (w_in_range) r_wr_idx <= w_idx;
      end else if (bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  assign bvalid   = r_bvalid;
  assign bresp    = r_bresp;
  assign wr_pulse = r_wr_pulse;
  assign wr_idx   = r_wr_idx;

  axi_lite_regfile #(
    .DATA_WD  (DATA_WD),
    .NUM_REGS (NUM_REGS),
    .IDX_WD   (IDX_WD)
  ) u_regfile (
    .clk      (clk),
    .rstn     (rstn),
    .we       (w_commit && w_in_range),
    .idx      (w_idx),
    .wdata    (r_wdata),
`ifdef AXI_LITE_WSTRB_EN
    .wstrb    (r_wstrb),
`endif
    .reg_flat (reg_flat)
  );

endmodule

// File: doc/axi_lite_write_slave.md
Name: axi_lite_write_slave

Overview:
- AXI-lite write responder. Accepts independent AW and W handshakes, commits the write into an internal register file and returns a B response.
- Sits between the AXI-lite write master/interconnect and control/status logic.
- Register contents and a per-write pulse are exported to downstream logic.

Parameters:
- DATA_WD, 8, data width in bits; must be a multiple of 8.
- ADDR_WD, 8, byte-address width.
- NUM_REGS, 16, number of DATA_WD-bit registers; must be 1 or more.
- ADDR_LSB, $clog2(DATA_WD/8), derived local parameter; the register index is awaddr[ADDR_WD-1:ADDR_LSB].

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- awaddr  in  ADDR_WD  write byte address
- awvalid  in  1  address valid
- awready  out  1  address ready
- wdata  in  DATA_WD  write data
- wvalid  in  1  data valid
- wready  out  1  data ready
- bresp  out  2  write response
- bvalid  out  1  response valid
- bready  in  1  response ready
- reg_flat  out  NUM_REGS*DATA_WD  all registers; register i occupies bits [i*DATA_WD +: DATA_WD]
- wr_pulse  out  1  one-cycle pulse on each successful register write
- wr_idx  out  $clog2(NUM_REGS) (1 if NUM_REGS=1)  index of the register written; valid with wr_pulse

Behaviour:
- Reset values: awready=0, wready=0, bvalid=0, bresp=2'b00, wr_pulse=0, wr_idx=0, all registers 0, aw_full=0, w_full=0, init_done=0.
- init_done is a register set to 1 on the first clk edge after reset release.
- awready = init_done && !aw_full. wready = init_done && !w_full.
- AW fire (awvalid && awready): latch awaddr, set aw_full.
- W fire (wvalid && wready): latch wdata, set w_full.
- AW and W may arrive in either order or in the same cycle. Each channel holds at most one beat.
- commit = aw_full && w_full && (!bvalid || bready). Evaluated combinationally from registered state.
- On commit (takes effect at the next edge):
  - clear aw_full and w_full;
  - set bvalid;
  - if idx < NUM_REGS: write the register, bresp=2'b00 (OKAY), wr_pulse=1, wr_idx=idx;
  - otherwise: no write, bresp=2'b10 (SLVERR), wr_pulse=0.
- B channel:
  - bvalid clears on bready when no new commit occurs in the same cycle.
  - If bready and commit coincide, bvalid stays 1 and bresp updates to the new response (back-to-back responses).
  - bresp is stable while bvalid && !bready.
- Latency: AW and W fire at edge N → bvalid high after edge N+1. Minimum of 2 cycles per transaction per channel (ready drops for one cycle after each fire).
- Backpressure: while bvalid && !bready, a fully buffered transaction waits and both readys stay low. Neither AW nor W data is lost.
- wr_pulse is high for exactly one cycle per successful write.
- Reset mid-operation: all buffered beats and any pending response are discarded, and outputs return to reset values.

Optional Feature:
- Macro: AXI_LITE_WSTRB_EN.
- Defined: adds input port wstrb, width DATA_WD/8, latched with wdata. Byte lane k is written only if wstrb[k]=1; other lanes keep their old value. The response is unchanged. A write with wstrb=0 still returns OKAY and still pulses wr_pulse.
- Undefined: no wstrb port; all byte lanes are written.

Decomposition:
- Package axi_lite_pkg holds the response encodings:
  - RESP_OKAY = 2'b00
  - RESP_EXOKAY = 2'b01
  - RESP_SLVERR = 2'b10
  - RESP_DECERR = 2'b11
- Sub-module axi_lite_regfile holds the NUM_REGS storage, the strobe merge (under AXI_LITE_WSTRB_EN) and the reg_flat packing. Inputs: we, idx, wdata, wstrb.

Test Plan:
- AW addr 0x03 and W 0xA5 in the same cycle, bready=1 → bvalid 2 cycles later, bresp=00, reg3=0xA5, wr_pulse for 1 cycle with wr_idx=3.
- W 0x5A sent 3 cycles before AW addr 0x07 → wready=0 after the W fire, no commit until AW arrives, then bresp=00 and reg7=0x5A.
- AW addr 0x20 (idx 32 ≥ 16) with W 0xFF → bresp=10, all registers unchanged, wr_pulse never asserted.
- bready held 0 for 5 cycles while a second AW/W (addr 0x01, data 0x11) is issued → awready and wready go low, first bresp is held stable, second write is not committed. After bready rises, the second response follows the next cycle and reg1=0x11.
- rstn pulsed low after AW is captured but before W → no bvalid, registers 0, awready=0 for 1 cycle after release then 1.
- With AXI_LITE_WSTRB_EN and DATA_WD=32: reg0=0x12345678, write 0xAABBCCDD to addr 0x00 with wstrb=4'b0101 → reg0=0x12BB56DD, bresp=00.
